lane_game_ctrl: RTL and testbench

//  Parametrised successor of the 3-lane dodge-game controller: scrolls a DEPTH-row barrier field past a
//  car with LANES lanes and half-step animation, selectable speed (3 levels), hit-consumed shields, saturating

---
 rtl/lane_game_pkg.sv | 22 ++
 rtl/lane_game_tick.sv | 38 +++
 rtl/lane_game_ctrl.sv | 132 +++++++++++++
 tb/tb_lane_game_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_game_pkg.sv
// lane_game_pkg: shared state encoding, move codes and helper functions for the lane game
package lane_game_pkg;

    typedef enum logic [3:0] {
        LOAD, MOVE, SHOW_MID, HALF_WAIT, SETTLE, CHECK, SHOW_FIN, END_WAIT, OVER
    } state_t;

    localparam logic [1:0] MV_HOLD = 2'b00;
    localparam logic [1:0] MV_DN   = 2'b01;
    localparam logic [1:0] MV_UP   = 2'b10;

    // Lane mask occupied by a car position; between-lane positions occupy no lane
    function automatic logic [31:0] lane_bits(input int pos);
        return pos[0] ? 32'd0 : 32'd1 << (pos >> 1);
    endfunction

    // LSB-first thermometer code of n
    function automatic logic [31:0] therm(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/lane_game_tick.sv
// lane_game_tick: per-frame period select and frame timer with half/end compares
module lane_game_tick #(
    parameter int TICK_CYC = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       start,
    input  logic       run,
    input  logic       wrap,
    input  logic [1:0] speed_sel,
    output logic       half_hit,
    output logic       end_hit
);
    localparam int TW = $clog2(TICK_CYC) + 1;

    logic [TW-1:0] period, timer;

    assign half_hit = timer == (period >> 1);
    assign end_hit  = timer == period - TW'(1);

    // Period latched when a row is accepted; speed 3 behaves as speed 2
    always_ff @(posedge clk or posedge rst)
        if (rst)
            period <= TW'(TICK_CYC);
        else if (start)
            period <= TW'(TICK_CYC) >> (speed_sel[1] ? 2'd2 : {1'b0, speed_sel[0]});

    // Timer sits at 0 while waiting for a row and counts every cycle of a frame
    always_ff @(posedge clk or posedge rst)
        if (rst)
            timer <= '0;
        else if (clr || wrap)
            timer <= '0;
        else if (start || run)
            timer <= timer + TW'(1);

endmodule

// File: rtl/lane_game_ctrl.sv
// lane_game_ctrl: scrolling lane-dodge controller between a barrier row source and a matrix display
module lane_game_ctrl
    import lane_game_pkg::*;
#(
    parameter int LANES    = 3,
    parameter int DEPTH    = 8,
    parameter int VIS_ROWS = 6,
    parameter int TICK_CYC = 12500000,
    parameter int SHIELDS  = 4,
    parameter int SCORE_W  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   restart,
    input  logic [1:0]                             speed_sel,
    input  logic                                   shield_en,
    input  logic [1:0]                             car_move,
    input  logic [LANES-1:0]                       barrier_in,
    input  logic                                   barrier_valid,
    output logic                                   barrier_req,
    output logic [2*LANES-1+VIS_ROWS*LANES-1:0]    frame_data,
    output logic                                   frame_valid,
    output logic                                   gameover,
    output logic [SCORE_W-1:0]                     score,
    output logic [SHIELDS-1:0]                     shield_bar
);
    localparam int CP = 2 * LANES - 1;
    localparam int PW = $clog2(CP);

    state_t                      state, state_nx;
    logic [DEPTH-1:0][LANES-1:0] rows;
    logic [PW-1:0]               pos;
    logic [1:0]                  mv;
    logic [3:0]                  shields;
    logic [CP-1:0]               car;
    logic                        accept, hit, save, init, half_hit, end_hit;

    assign car        = CP'(1) << pos;
    assign accept     = state == LOAD && barrier_req && barrier_valid;
    assign hit        = |(rows[0] & LANES'(lane_bits(int'(pos))));
    assign save       = hit && shield_en && shields != 4'd0;
    assign init       = state == OVER && restart;
    assign shield_bar = SHIELDS'(therm(int'(shields)));

    lane_game_tick #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (init),
        .start     (accept),
        .run       (state != LOAD && state != OVER),
        .wrap      (state == END_WAIT && end_hit),
        .speed_sel (speed_sel),
        .half_hit  (half_hit),
        .end_hit   (end_hit)
    );

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= LOAD;
        else
            state <= state_nx;

    // Next-state: one state per cycle except the row wait, the two timer waits and game over
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:      state_nx = accept ? MOVE : LOAD;
            MOVE:      state_nx = SHOW_MID;
            SHOW_MID:  state_nx = HALF_WAIT;
            HALF_WAIT: state_nx = half_hit ? SETTLE : HALF_WAIT;
            SETTLE:    state_nx = CHECK;
            CHECK:     state_nx = hit && !save ? OVER : SHOW_FIN;
            SHOW_FIN:  state_nx = END_WAIT;
            END_WAIT:  state_nx = end_hit ? LOAD : END_WAIT;
            OVER:      state_nx = restart ? LOAD : OVER;
            default:   state_nx = LOAD;
        endcase
    end

    // Field, car, score, shields and registered display/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows        <= '0;
            pos         <= PW'(LANES - 1);
            mv          <= MV_HOLD;
            score       <= '0;
            shields     <= 4'(SHIELDS);
            frame_data  <= '0;
            frame_valid <= 1'b0;
            gameover    <= 1'b0;
            barrier_req <= 1'b0;
        end else if (init) begin
            rows        <= '0;
            pos         <= PW'(LANES - 1);
            mv          <= MV_HOLD;
            score       <= '0;
            shields     <= 4'(SHIELDS);
            frame_data  <= '0;
            frame_valid <= 1'b0;
            gameover    <= 1'b0;
            barrier_req <= 1'b0;
        end else begin
            barrier_req <= state_nx == LOAD;
            gameover    <= state_nx == OVER;
            frame_valid <= state == SHOW_MID || state == SHOW_FIN;
            case (state)
                LOAD: if (accept) begin
                    rows  <= {barrier_in, rows[DEPTH-1:1]};
                    score <= score + SCORE_W'(~&score);
                end
                MOVE: begin
                    mv <= car_move;
                    if (!pos[0] && car_move == MV_DN && pos != '0)
                        pos <= pos - PW'(1);
                    else if (!pos[0] && car_move == MV_UP && pos != PW'(CP - 1))
                        pos <= pos + PW'(1);
                end
                SHOW_MID: frame_data <= {rows[DEPTH-1 -: VIS_ROWS], car};
                SETTLE: begin
                    rows <= {LANES'(0), rows[DEPTH-1:1]};
                    if (pos[0])
                        pos <= mv == MV_DN ? pos - PW'(1) : pos + PW'(1);
                end
                CHECK: if (save) shields <= shields - 4'd1;
                SHOW_FIN: frame_data <= {rows[VIS_ROWS:1], car};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_game_ctrl.sv
// tb_lane_game_ctrl: table, directed and randomized checks of lane_game_ctrl against a frame-schedule model
module tb_lane_game_ctrl;
    localparam int LANES = 3, DEPTH = 8, VIS_ROWS = 6, TICK_CYC = 64, SHIELDS = 4, SCORE_W = 8;
    localparam int CP = 2 * LANES - 1;
    localparam int FW = CP + VIS_ROWS * LANES;

    logic clk = 0, rst = 0, restart = 0, shield_en = 0, barrier_valid = 0;
    logic [1:0] speed_sel = 0, car_move = 0;
    logic [LANES-1:0] barrier_in = 0;
    logic barrier_req, frame_valid, gameover;
    logic [FW-1:0] frame_data;
    logic [SCORE_W-1:0] score;
    logic [SHIELDS-1:0] shield_bar;

    lane_game_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .VIS_ROWS(VIS_ROWS), .TICK_CYC(TICK_CYC),
                     .SHIELDS(SHIELDS), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst(rst), .restart(restart), .speed_sel(speed_sel), .shield_en(shield_en),
        .car_move(car_move), .barrier_in(barrier_in), .barrier_valid(barrier_valid),
        .barrier_req(barrier_req), .frame_data(frame_data), .frame_valid(frame_valid),
        .gameover(gameover), .score(score), .shield_bar(shield_bar));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Game model: field as an int array, frame progress as cycles since the row was taken
    int m_rows[DEPTH];
    int m_pos, m_mv, m_score, m_sh, m_per, m_t;
    bit m_load, m_req, m_over, m_fv;
    logic [FW-1:0] m_fd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input int base);
        logic [FW-1:0] f = FW'(1) << m_pos;
        for (int i = 0; i < VIS_ROWS; i++) f |= FW'(m_rows[base + i]) << (CP + LANES * i);
        return f;
    endfunction

    task automatic minit();
        foreach (m_rows[k]) m_rows[k] = 0;
        m_pos = LANES - 1; m_mv = 0; m_score = 0; m_sh = SHIELDS; m_per = TICK_CYC; m_t = 0;
        m_load = 1; m_req = 0; m_over = 0; m_fv = 0; m_fd = '0;
    endtask

    task automatic model_step();
        bit fvn = 0;
        int h = m_per / 2;
        if (rst) begin minit(); return; end
        if (m_over) begin
            if (restart) minit();
        end else if (m_load) begin
            if (m_req && barrier_valid) begin
                for (int k = 0; k < DEPTH - 1; k++) m_rows[k] = m_rows[k + 1];
                m_rows[DEPTH - 1] = int'(barrier_in);
                if (m_score < (1 << SCORE_W) - 1) m_score++;
                m_per = TICK_CYC >> (speed_sel > 2 ? 2 : int'(speed_sel));
                m_load = 0; m_req = 0; m_t = 1;
                h = m_per / 2;
            end else m_req = 1;
        end else begin
            if (m_t == 1) begin
                m_mv = int'(car_move);
                if (m_pos % 2 == 0 && m_mv == 1 && m_pos > 0) m_pos--;
                else if (m_pos % 2 == 0 && m_mv == 2 && m_pos < CP - 1) m_pos++;
            end else if (m_t == 2) begin
                m_fd = frame_of(DEPTH - VIS_ROWS); fvn = 1;
            end else if (m_t == h + 1) begin
                for (int k = 0; k < DEPTH - 1; k++) m_rows[k] = m_rows[k + 1];
                m_rows[DEPTH - 1] = 0;
                if (m_pos % 2 == 1) m_pos += (m_mv == 1) ? -1 : 1;
            end else if (m_t == h + 2) begin
                if (m_pos % 2 == 0 && ((m_rows[0] >> (m_pos / 2)) & 1) == 1) begin
                    if (shield_en && m_sh > 0) m_sh--;
                    else m_over = 1;
                end
            end else if (m_t == h + 3) begin
                m_fd = frame_of(1); fvn = 1;
            end
            if (!m_over) begin
                if (m_t == m_per - 1) begin m_load = 1; m_req = 1; end
                else m_t++;
            end
        end
        m_fv = fvn;
    endtask

    task automatic check_all();
        chk("frame_valid", frame_valid, m_fv);
        chk("barrier_req", barrier_req, m_req);
        chk("gameover", gameover, m_over);
        chk("score", score, m_score);
        chk("shield_bar", shield_bar, (1 << m_sh) - 1);
        chk("frame_data", frame_data, m_fd);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_strobe(input string nm, output int at);
        int n = 0;
        do begin tick(); n++; end while (!frame_valid && n < 200);
        at = cyc;
        if (!frame_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no frame strobe within 200 cycles", nm);
        end
    endtask

    // Asserted between clock edges so the asynchronous path is what clears the outputs
    task automatic do_reset();
        #2 rst = 1;
        #1 minit();
        chk("rst_req", barrier_req, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_score", score, 0);
        chk("rst_shield", shield_bar, 4'hF);
        chk("rst_frame", frame_data, 0);
        chk("rst_over", gameover, 0);
        tick();
        rst = 0;
    endtask

    typedef struct { logic [1:0] mv; int mid; int fin; } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, t4, n, c_req, c_fv;
        tbl[0] = '{2'b10, 3, 4}; tbl[1] = '{2'b10, 4, 4}; tbl[2] = '{2'b11, 4, 4};
        tbl[3] = '{2'b01, 3, 2}; tbl[4] = '{2'b01, 1, 0}; tbl[5] = '{2'b01, 0, 0};
        tbl[6] = '{2'b00, 0, 0}; tbl[7] = '{2'b10, 1, 2};
        do_reset();
        barrier_valid = 1;
        foreach (tbl[i]) begin
            car_move = tbl[i].mv;
            wait_strobe("tbl_mid", t0);
            chk($sformatf("tbl%0d_mid_car", i), frame_data[CP-1:0], CP'(1) << tbl[i].mid);
            wait_strobe("tbl_fin", t0);
            chk($sformatf("tbl%0d_fin_car", i), frame_data[CP-1:0], CP'(1) << tbl[i].fin);
        end

        // single barrier in the centre lane, no shields allowed
        do_reset();
        car_move = 0; shield_en = 0; barrier_in = 3'b010;
        wait_strobe("hit_first", t0);
        barrier_in = 0;
        n = 0;
        while (!gameover && n < 1000) begin tick(); n++; end
        chk("over_noshield", gameover, 1);
        c_req = 0; c_fv = 0;
        repeat (200) begin tick(); c_req += barrier_req; c_fv += frame_valid; end
        chk("over_req", c_req, 0);
        chk("over_strobes", c_fv, 0);
        restart = 1; tick(); restart = 0;
        chk("restart_score", score, 0);
        chk("restart_over", gameover, 0);

        // continuous centre barriers with shields: four saved hits, fifth ends the game
        do_reset();
        shield_en = 1; barrier_in = 3'b010;
        n = 0;
        while (shield_bar == 4'hF && n < 1000) begin tick(); n++; end
        chk("shield_first", shield_bar, 4'b0111);
        chk("shield_alive", gameover, 0);
        n = 0;
        while (!gameover && n < 1000) begin tick(); n++; end
        chk("shield_empty", shield_bar, 0);
        chk("shield_over", gameover, 1);

        // speed change mid-frame applies from the next frame
        restart = 1; tick(); restart = 0;
        shield_en = 0; barrier_in = 0; speed_sel = 0;
        wait_strobe("spd_a_mid", t0);
        speed_sel = 2;
        wait_strobe("spd_a_fin", t1);
        wait_strobe("spd_b_mid", t1);
        wait_strobe("spd_b_fin", t2);
        wait_strobe("spd_c_mid", t2);
        chk("speed0_period", t1 - t0, 64);
        chk("speed2_period", t2 - t1, 16);
        speed_sel = 3;
        wait_strobe("spd_c_fin", t3);
        wait_strobe("spd_d_mid", t3);
        wait_strobe("spd_d_fin", t4);
        wait_strobe("spd_e_mid", t4);
        chk("speed3_period", t4 - t3, 16);

        // no row offered: controller waits in LOAD
        n = 0;
        while (!barrier_req && n < 200) begin tick(); n++; end
        barrier_valid = 0;
        c_req = 0; c_fv = 0;
        repeat (100) begin tick(); c_req += barrier_req; c_fv += frame_valid; end
        chk("stall_req", c_req, 100);
        chk("stall_strobes", c_fv, 0);
        barrier_valid = 1;

        // score saturation
        n = 0;
        while (score != 8'hFF && n < 8000) begin tick(); n++; end
        chk("score_sat", score, 8'hFF);
        repeat (4) wait_strobe("sat_frames", t0);
        chk("score_sat_hold", score, 8'hFF);

        // reset in the middle of a frame
        wait_strobe("pre_rst", t0);
        tick();
        do_reset();

        // randomized play
        repeat (4000) begin
            car_move = 2'($urandom_range(0, 3));
            barrier_valid = $urandom_range(0, 3) != 0;
            barrier_in = ($urandom_range(0, 2) == 0) ? LANES'($urandom) : '0;
            if ($urandom_range(0, 99) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) shield_en = ~shield_en;
            restart = $urandom_range(0, 19) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
